draw_rotated_sprite: RTL and testbench

- Parametrised successor to the per-object sprite drawers (ship, asteroids).
- Stores only one quadrant of angle frames in a single external frame ROM. Rotations of 0/90/180/270 deg are produced by address remapping, replacing per-rotation ROM copies and the large direction mux.
- Adds a transparent colour key, so background pixels are not written.
- Sits between the game-object FSM (start, position, frame and quadrant select) and the VGA adapter write port.

---
 rtl/draw_rotated_sprite.sv | 171 +++++++++++++++++
 tb/tb_draw_rotated_sprite.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_rotated_sprite.sv
// ---------------------------------------------------------------------------
// draw_rotated_sprite
//
// Draws one SIZE x SIZE sprite into a pixel write port, reading colours from
// an external frame ROM that holds only one quadrant's worth of angle frames.
// The 90/180/270 degree rotations come from remapping the ROM row/column
// address, so no extra ROM copies are needed. Pixels whose colour matches
// the transparent key can be suppressed so the background shows through.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   start               draw request (only honoured while idle)
//   x_pos, y_pos        sprite top-left screen position
//   frame               angle frame within the quadrant (clamped to FRAMES-1)
//   quadrant            0=0, 1=90 CW, 2=180, 3=270 CW
//   rom_addr            frame ROM address {frame, src_row, src_col}
//   rom_data            frame ROM read data, one cycle after rom_addr
//   x, y, color         pixel being written
//   write_en            pixel write strobe
//   busy                high from the first address cycle to draw_done
//   draw_done           one-cycle completion pulse
// ---------------------------------------------------------------------------
module draw_rotated_sprite #(
    parameter int                 SIZE        = 32,
    parameter int                 SIZE_LOG2   = 5,
    parameter int                 FRAMES      = 6,
    parameter int                 FRAME_W     = 3,
    parameter int                 COORD_W     = 10,
    parameter int                 COLOR_W     = 3,
    parameter int                 TRANSP_EN   = 1,
    parameter logic [COLOR_W-1:0] TRANSPARENT = '0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [COORD_W-1:0]             x_pos,
    input  logic [COORD_W-1:0]             y_pos,
    input  logic [FRAME_W-1:0]             frame,
    input  logic [1:0]                     quadrant,
    output logic [FRAME_W+2*SIZE_LOG2-1:0] rom_addr,
    input  logic [COLOR_W-1:0]             rom_data,
    output logic [COORD_W-1:0]             x,
    output logic [COORD_W-1:0]             y,
    output logic [COLOR_W-1:0]             color,
    output logic                           write_en,
    output logic                           busy,
    output logic                           draw_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAW  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Last row/column index; also the "M" used by the rotation mapping.
    localparam logic [SIZE_LOG2-1:0] LAST       = SIZE_LOG2'(SIZE - 1);
    // One extra bit so FRAMES == 2**FRAME_W still compares correctly.
    localparam logic [FRAME_W:0]     FRAMES_EXT = (FRAME_W + 1)'(FRAMES);
    localparam logic [FRAME_W-1:0]   FRAME_MAX  = FRAME_W'(FRAMES - 1);

    // Destination (r, c) -> source {row, col} inside the stored frame.
    function automatic logic [2*SIZE_LOG2-1:0] src_rc(
        input logic [1:0]           q,
        input logic [SIZE_LOG2-1:0] r,
        input logic [SIZE_LOG2-1:0] c
    );
        case (q)
            2'd0:    src_rc = {r, c};
            2'd1:    src_rc = {LAST - c, r};
            2'd2:    src_rc = {LAST - r, LAST - c};
            default: src_rc = {c, LAST - r};
        endcase
    endfunction

    state_t                 state_q,   state_d;
    logic [SIZE_LOG2-1:0]   row_q,     row_d;
    logic [SIZE_LOG2-1:0]   col_q,     col_d;
    logic [COORD_W-1:0]     x_l_q,     x_l_d;
    logic [COORD_W-1:0]     y_l_q,     y_l_d;
    logic [FRAME_W-1:0]     frame_l_q, frame_l_d;
    logic [1:0]             quad_l_q,  quad_l_d;
    logic                   vld_p1_q,  vld_p1_d;
    logic [SIZE_LOG2-1:0]   row_p1_q,  row_p1_d;
    logic [SIZE_LOG2-1:0]   col_p1_q,  col_p1_d;

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        x_l_d     = x_l_q;
        y_l_d     = y_l_q;
        frame_l_d = frame_l_q;
        quad_l_d  = quad_l_q;
        vld_p1_d  = 1'b0;
        row_p1_d  = row_p1_q;
        col_p1_d  = col_p1_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_l_d     = x_pos;
                    y_l_d     = y_pos;
                    quad_l_d  = quadrant;
                    frame_l_d = ({1'b0, frame} >= FRAMES_EXT) ? FRAME_MAX : frame;
                    row_d     = '0;
                    col_d     = '0;
                    state_d   = S_DRAW;
                end
            end
            S_DRAW: begin
                // Destination coordinates travel with the ROM read so they
                // line up with rom_data one cycle later.
                vld_p1_d = 1'b1;
                row_p1_d = row_q;
                col_p1_d = col_q;
                // SIZE is a power of two, so the increment wraps on its own.
                col_d    = col_q + SIZE_LOG2'(1);
                if (col_q == LAST) begin
                    row_d = row_q + SIZE_LOG2'(1);
                    if (row_q == LAST) begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            row_q     <= '0;
            col_q     <= '0;
            x_l_q     <= '0;
            y_l_q     <= '0;
            frame_l_q <= '0;
            quad_l_q  <= '0;
            vld_p1_q  <= 1'b0;
            row_p1_q  <= '0;
            col_p1_q  <= '0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            x_l_q     <= x_l_d;
            y_l_q     <= y_l_d;
            frame_l_q <= frame_l_d;
            quad_l_q  <= quad_l_d;
            vld_p1_q  <= vld_p1_d;
            row_p1_q  <= row_p1_d;
            col_p1_q  <= col_p1_d;
        end
    end

    // Address stage: ROM address from the current raster position.
    assign rom_addr = {frame_l_q, src_rc(quad_l_q, row_q, col_q)};

    // Pixel stage: ROM data is valid together with the p1 registers.
    // Screen coordinates wrap modulo 2**COORD_W; no clipping is done.
    assign x         = x_l_q + COORD_W'(col_p1_q);
    assign y         = y_l_q + COORD_W'(row_p1_q);
    assign color     = rom_data;
    assign write_en  = vld_p1_q && !((TRANSP_EN != 0) && (rom_data == TRANSPARENT));
    assign busy      = (state_q != S_IDLE);
    assign draw_done = (state_q == S_DONE);

endmodule

// File: tb/tb_draw_rotated_sprite.sv
`timescale 1ns/1ps
module tb_draw_rotated_sprite;

    localparam int SIZE = 4;
    localparam int N    = SIZE * SIZE;
    localparam int M    = SIZE - 1;
    localparam int NDUT = 3;   // 0: reference setup, 1: TRANSP_EN=0, 2: FRAMES=1

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [9:0] x_pos = '0;
    logic [9:0] y_pos = '0;
    logic [0:0] frame = '0;
    logic [1:0] quadrant = '0;

    logic [NDUT*5-1:0]  ra_all;
    logic [NDUT*10-1:0] x_all;
    logic [NDUT*10-1:0] y_all;
    logic [NDUT*3-1:0]  co_all;
    logic [NDUT-1:0]    we_all;
    logic [NDUT-1:0]    busy_all;
    logic [NDUT-1:0]    done_all;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    int cur_c  = 0;
    int we_cnt   [NDUT];
    int done_cnt [NDUT];

    always #5 clk = ~clk;

    // ---------------- reference model helpers ----------------
    // Source address: rotate the destination (r,c) by q quarter turns CW.
    function automatic int src_addr(input int q, input int f, input int r, input int c);
        int sr, sc, tmp;
        sr = r;
        sc = c;
        for (int i = 0; i < q; i++) begin
            tmp = sr;
            sr  = M - sc;
            sc  = tmp;
        end
        return f * SIZE * SIZE + sr * SIZE + sc;
    endfunction

    function automatic int rom_val(input int a);
        return (a == 0) ? 0 : ((a % 16) % 7 + 1);
    endfunction

    function automatic int frames_of(input int g);
        return (g == 2) ? 1 : 2;
    endfunction

    function automatic int transp_of(input int g);
        return (g == 1) ? 0 : 1;
    endfunction

    function automatic int eff_frame(input int g, input int f);
        return (f >= frames_of(g)) ? frames_of(g) - 1 : f;
    endfunction

    task automatic chk(input string nm, input int g, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t got %0d expected %0d", nm, g, $time, act, exp);
        end
    endtask

    // ---------------- DUTs and ROM models ----------------
    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        logic [4:0] ra;
        logic [2:0] rd;
        logic [9:0] xo, yo;
        logic [2:0] co;
        logic       we, bz, dn;

        draw_rotated_sprite #(
            .SIZE(4), .SIZE_LOG2(2), .FRAMES((g == 2) ? 1 : 2), .FRAME_W(1),
            .COORD_W(10), .COLOR_W(3), .TRANSP_EN((g == 1) ? 0 : 1),
            .TRANSPARENT(3'b000)
        ) u_dut (
            .clk(clk), .reset(reset), .start(start),
            .x_pos(x_pos), .y_pos(y_pos), .frame(frame), .quadrant(quadrant),
            .rom_addr(ra), .rom_data(rd),
            .x(xo), .y(yo), .color(co),
            .write_en(we), .busy(bz), .draw_done(dn)
        );

        always @(posedge clk) rd <= 3'(rom_val(int'(ra)));

        assign ra_all[g*5 +: 5]   = ra;
        assign x_all[g*10 +: 10]  = xo;
        assign y_all[g*10 +: 10]  = yo;
        assign co_all[g*3 +: 3]   = co;
        assign we_all[g]          = we;
        assign busy_all[g]        = bz;
        assign done_all[g]        = dn;
    end

    // ---------------- timeline model ----------------
    // m_t is the cycle number counted from the accepting edge (cycle 1 first).
    int m_t = 0;
    bit m_act = 1'b0;
    int m_x = 0, m_y = 0, m_q = 0, m_f = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_act = 1'b0;
            m_t   = 0;
        end else if (!m_act) begin
            if (start) begin
                m_act = 1'b1;
                m_t   = 1;
                m_x   = int'(x_pos);
                m_y   = int'(y_pos);
                m_q   = int'(quadrant);
                m_f   = int'(frame);
            end
        end else begin
            m_t++;
            if (m_t == N + 3) m_act = 1'b0;
        end
    end

    // ---------------- per-cycle compare ----------------
    int  c_fe, c_k, c_a, c_col;
    bit  c_pv, c_we;

    always @(negedge clk) begin
        if (chk_en) begin
            for (int g = 0; g < NDUT; g++) begin
                c_fe = eff_frame(g, m_f);
                chk("busy", g, int'(busy_all[g]), int'(m_act));
                chk("draw_done", g, int'(done_all[g]), int'(m_act && m_t == N + 2));
                if (m_act && m_t <= N) begin
                    c_k = m_t - 1;
                    c_a = src_addr(m_q, c_fe, c_k / SIZE, c_k % SIZE);
                    chk("rom_addr", g, int'(ra_all[g*5 +: 5]), c_a);
                end
                c_pv = m_act && m_t >= 2 && m_t <= N + 1;
                c_we = 1'b0;
                if (c_pv) begin
                    c_k   = m_t - 2;
                    c_a   = src_addr(m_q, c_fe, c_k / SIZE, c_k % SIZE);
                    c_col = rom_val(c_a);
                    c_we  = (transp_of(g) == 0) || (c_col != 0);
                    chk("x", g, int'(x_all[g*10 +: 10]), (m_x + c_k % SIZE) % 1024);
                    chk("y", g, int'(y_all[g*10 +: 10]), (m_y + c_k / SIZE) % 1024);
                    chk("color", g, int'(co_all[g*3 +: 3]), c_col);
                end
                chk("write_en", g, int'(we_all[g]), int'(c_we));
                if (m_act && m_t == 1) we_cnt[g] = 0;
                if (we_all[g]) we_cnt[g]++;
                if (done_all[g]) done_cnt[g]++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic launch(input int xp, input int yp, input int q, input int f);
        x_pos    = 10'(xp);
        y_pos    = 10'(yp);
        quadrant = 2'(q);
        frame    = 1'(f);
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cur_c = 1;
    endtask

    // Move to the sampling point (negedge) of cycle c of the current draw.
    task automatic at_cycle(input int c);
        repeat (c - cur_c) @(posedge clk);
        cur_c = c;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    int d0;
    int q_exp [3] = '{12, 15, 3};

    initial begin
        // Pin the model against hand-derived values.
        chk("pin_q1_r0c0", 0, src_addr(1, 0, 0, 0), 12);
        chk("pin_q2_r0c0", 0, src_addr(2, 0, 0, 0), 15);
        chk("pin_q3_r0c0", 0, src_addr(3, 0, 0, 0), 3);
        chk("pin_q1_r1c2", 0, src_addr(1, 0, 1, 2), 5);
        chk("pin_rom0", 0, rom_val(0), 0);
        chk("pin_rom31", 0, rom_val(31), 2);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(negedge clk);
        for (int g = 0; g < NDUT; g++) begin
            chk("rst_x", g, int'(x_all[g*10 +: 10]), 0);
            chk("rst_y", g, int'(y_all[g*10 +: 10]), 0);
            chk("rst_rom_addr", g, int'(ra_all[g*5 +: 5]), 0);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Basic draw, q0 frame1
        launch(100, 50, 0, 1);
        at_cycle(1);
        chk("basic_busy_c1", 0, int'(busy_all[0]), 1);
        chk("basic_addr_c1", 0, int'(ra_all[4:0]), 16);
        at_cycle(2);
        chk("basic_x_c2", 0, int'(x_all[9:0]), 100);
        chk("basic_y_c2", 0, int'(y_all[9:0]), 50);
        chk("basic_we_c2", 0, int'(we_all[0]), 1);
        at_cycle(17);
        chk("basic_x_c17", 0, int'(x_all[9:0]), 103);
        chk("basic_y_c17", 0, int'(y_all[9:0]), 53);
        chk("basic_color_c17", 0, int'(co_all[2:0]), 2);
        at_cycle(18);
        chk("basic_done_c18", 0, int'(done_all[0]), 1);
        at_cycle(19);
        chk("basic_busy_c19", 0, int'(busy_all[0]), 0);
        chk("basic_pulses", 0, we_cnt[0], 16);
        chk("clamp_pulses", 2, we_cnt[2], 15);

        // Rotations, frame 0
        for (int q = 1; q <= 3; q++) begin
            launch(200, 100, q, 0);
            at_cycle(1);
            chk("rot_addr_r0c0", 0, int'(ra_all[4:0]), q_exp[q-1]);
            if (q == 1) begin
                at_cycle(7);
                chk("rot_q1_addr_r1c2", 0, int'(ra_all[4:0]), 5);
            end
            at_cycle(N + 3);
        end

        // Transparency
        launch(10, 20, 0, 0);
        at_cycle(N + 3);
        chk("transp_pulses", 0, we_cnt[0], 15);
        chk("opaque_pulses", 1, we_cnt[1], 16);
        chk("transp_pulses", 2, we_cnt[2], 15);

        // Coordinate wrap and frame clamp
        launch(1022, 1022, 2, 1);
        at_cycle(1);
        chk("wrap_addr_c1", 0, int'(ra_all[4:0]), 31);
        chk("clamp_addr_c1", 2, int'(ra_all[14:10]), 15);
        at_cycle(2);
        chk("wrap_x0", 0, int'(x_all[9:0]), 1022);
        at_cycle(3);
        chk("wrap_x1", 0, int'(x_all[9:0]), 1023);
        at_cycle(4);
        chk("wrap_x2", 0, int'(x_all[9:0]), 0);
        at_cycle(5);
        chk("wrap_x3", 0, int'(x_all[9:0]), 1);
        at_cycle(14);
        chk("wrap_y3", 0, int'(y_all[9:0]), 1);
        at_cycle(N + 3);

        // Inputs changing mid-draw
        launch(300, 400, 0, 0);
        at_cycle(5);
        x_pos = 10'd7;
        y_pos = 10'd9;
        quadrant = 2'd3;
        frame = 1'b1;
        at_cycle(10);
        chk("latched_x", 0, int'(x_all[9:0]), 300);
        chk("latched_y", 0, int'(y_all[9:0]), 402);
        at_cycle(N + 3);

        // Reset mid-draw
        launch(50, 60, 1, 1);
        at_cycle(7);
        d0 = done_cnt[0];
        reset = 1'b1;
        at_cycle(8);
        chk("rst_mid_we", 0, int'(we_all[0]), 0);
        chk("rst_mid_busy", 0, int'(busy_all[0]), 0);
        reset = 1'b0;
        repeat (25) @(negedge clk);
        chk("rst_mid_no_done", 0, done_cnt[0] - d0, 0);

        // start held high
        start = 1'b1;
        @(posedge clk);
        #1;
        cur_c = 1;
        at_cycle(N + 2);
        chk("held_done", 0, int'(done_all[0]), 1);
        at_cycle(N + 3);
        chk("held_idle", 0, int'(busy_all[0]), 0);
        at_cycle(N + 4);
        chk("held_restart", 0, int'(busy_all[0]), 1);
        start = 1'b0;
        at_cycle(2 * N + 6);
        chk("held_end_idle", 0, int'(busy_all[0]), 0);

        // Randomized draws with noisy inputs while busy
        for (int it = 0; it < 25; it++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            launch(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 1)));
            for (int c = 1; c <= N + 2; c++) begin
                at_cycle(c);
                x_pos    = 10'($urandom);
                y_pos    = 10'($urandom);
                quadrant = 2'($urandom);
                frame    = 1'($urandom);
                start    = ($urandom_range(0, 3) == 0);
            end
            at_cycle(N + 3);
            start = 1'b0;
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
